micro_ucr_nonce_ctrl: RTL and testbench



---
 rtl/micro_ucr_pkg.sv | 18 +
 rtl/micro_ucr_target_cmp.sv | 14 +
 rtl/micro_ucr_nonce_ctrl.sv | 130 +++++++++++++
 tb/tb_micro_ucr_nonce_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/micro_ucr_pkg.sv
// Shared types and widths for the micro_ucr nonce-search controller.
package micro_ucr_pkg;

    localparam int HASH_W    = 24;
    localparam int NONCE_W   = 32;
    localparam int PAYLOAD_W = 96;
    localparam int BLOCK_W   = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_EXH   = 3'd5
    } state_t;

endpackage

// File: rtl/micro_ucr_target_cmp.sv
// Hit rule: both upper hash bytes strictly below the target (unsigned).
module micro_ucr_target_cmp
    import micro_ucr_pkg::*;
(
    input  logic [HASH_W-1:0] i_hash,
    input  logic [7:0]        i_target,
    output logic              o_hit
);

    always_comb begin
        o_hit = (i_hash[23:16] < i_target) && (i_hash[15:8] < i_target);
    end

endmodule

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce-search controller: restarts the hash core per nonce, waits CORE_LAT
// cycles, then checks the hash against the captured target.
module micro_ucr_nonce_ctrl
    import micro_ucr_pkg::*;
#(
    parameter int unsigned        CORE_LAT  = 34,
    parameter logic [NONCE_W-1:0] MAX_NONCE = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [7:0]           target,
    input  logic [HASH_W-1:0]    hash_in,
    output logic                 core_reset_L,
    output logic [BLOCK_W-1:0]   bloque_out,
    output logic                 fin,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [NONCE_W-1:0]   nonce_out,
    output logic [HASH_W-1:0]    hash_out
);

    localparam logic [7:0] LAT_LAST = 8'(CORE_LAT - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [7:0]             r_target;
    logic [NONCE_W-1:0]     r_nonce;
    logic [7:0]             r_cyc_cnt;
    logic [NONCE_W-1:0]     r_nonce_out;
    logic [HASH_W-1:0]      r_hash_out;
    logic [BLOCK_W-1:0]     r_bloque;
    logic                   w_hit;

    micro_ucr_target_cmp u_cmp (
        .i_hash   (hash_in),
        .i_target (r_target),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_next       = r_state;
        core_reset_L = 1'b0;
        fin          = 1'b0;
        busy         = 1'b0;
        found        = 1'b0;
        exhausted    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy   = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                busy         = 1'b1;
                core_reset_L = 1'b1;
                if (r_cyc_cnt == LAT_LAST) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy         = 1'b1;
                core_reset_L = 1'b1;
                fin          = 1'b1;
                if (w_hit)                     w_next = ST_DONE;
                else if (r_nonce == MAX_NONCE) w_next = ST_EXH;
                else                           w_next = ST_LOAD;
            end
            ST_DONE: begin
                core_reset_L = 1'b1;
                fin          = 1'b1;
                found        = 1'b1;
                if (start) w_next = ST_LOAD;
            end
            ST_EXH: begin
                core_reset_L = 1'b1;
                fin          = 1'b1;
                exhausted    = 1'b1;
                if (start) w_next = ST_LOAD;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // bloque_out is only rewritten on the edge that enters LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_payload   <= '0;
            r_target    <= '0;
            r_nonce     <= '0;
            r_cyc_cnt   <= '0;
            r_nonce_out <= '0;
            r_hash_out  <= '0;
            r_bloque    <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_EXH: begin
                    if (start) begin
                        r_payload <= payload;
                        r_target  <= target;
                        r_nonce   <= '0;
                        r_bloque  <= {payload, {NONCE_W{1'b0}}};
                    end
                end
                ST_LOAD: r_cyc_cnt <= '0;
                ST_RUN:  r_cyc_cnt <= r_cyc_cnt + 8'd1;
                ST_CHECK: begin
                    if (w_hit) begin
                        r_nonce_out <= r_nonce;
                        r_hash_out  <= hash_in;
                    end else if (r_nonce != MAX_NONCE) begin
                        r_nonce  <= r_nonce + 32'd1;
                        r_bloque <= {r_payload, r_nonce + 32'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bloque_out = r_bloque;
    assign nonce_out  = r_nonce_out;
    assign hash_out   = r_hash_out;

endmodule

// File: tb/tb_micro_ucr_nonce_ctrl.sv
// Directed bench for micro_ucr_nonce_ctrl with a table-driven core model
// and a scoreboard of expected search results.
module tb_micro_ucr_nonce_ctrl;

    localparam int          LAT  = 34;
    localparam int          PER  = LAT + 2;
    localparam logic [31:0] MAXN = 32'd5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [95:0]  payload;
    logic [7:0]   target;
    logic [23:0]  hash_in;
    logic         core_reset_L;
    logic [127:0] bloque_out;
    logic         fin, busy, found, exhausted;
    logic [31:0]  nonce_out;
    logic [23:0]  hash_out;

    micro_ucr_nonce_ctrl #(.CORE_LAT(LAT), .MAX_NONCE(MAXN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .payload      (payload),
        .target       (target),
        .hash_in      (hash_in),
        .core_reset_L (core_reset_L),
        .bloque_out   (bloque_out),
        .fin          (fin),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .nonce_out    (nonce_out),
        .hash_out     (hash_out)
    );

    always #5 clk = ~clk;

    // Core model: hash valid only once core_reset_L has been high LAT edges.
    logic [23:0] tbl [0:7];
    logic [7:0]  mcnt = 8'd0;
    always @(posedge clk) begin
        if (!core_reset_L)      mcnt <= 8'd0;
        else if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    end
    always_comb begin
        hash_in = 24'hFFFFFF;
        if (core_reset_L === 1'b1 && mcnt >= 8'(LAT)) hash_in = tbl[bloque_out[2:0]];
    end

    typedef struct {
        bit          f;
        bit          x;
        logic [31:0] nonce;
        logic [23:0] hash;
        int          loads;
        int          cycles;
        logic [95:0] pl;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 128'({core_reset_L, fin, busy, found, exhausted}), 128'(0));
        chk({tag, "_nonce_out"}, 128'(nonce_out), 128'(0));
        chk({tag, "_hash_out"}, 128'(hash_out), 128'(0));
        chk({tag, "_bloque"}, bloque_out, 128'(0));
    endtask

    task automatic set_tbl(input logic [23:0] v);
        for (int i = 0; i < 8; i++) tbl[i] = v;
    endtask

    task automatic launch(input logic [95:0] pl, input logic [7:0] tg, input exp_t e);
        payload = pl;
        target  = tg;
        start   = 1'b1;
        sbq.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        int   cyc   = 0;
        int   loads = 0;
        exp_t e;
        e = sbq[0];
        while (1) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_enter_load"}, 128'({busy, found, exhausted, core_reset_L}), 128'(4'b1000));
                chk({tag, "_load_block"}, bloque_out, {e.pl, 32'd0});
            end
            if (cyc == 5) begin
                // ignored mid-search start with a target that would always hit
                payload = ~e.pl;
                target  = 8'hFF;
                start   = 1'b1;
            end
            if (busy && !core_reset_L) loads++;
            if (found || exhausted || cyc > 8 * PER + 10) break;
        end
        e = sbq.pop_front();
        chk({tag, "_terminated"}, 128'(found | exhausted), 128'(1));
        chk({tag, "_found"}, 128'(found), 128'(e.f));
        chk({tag, "_exhausted"}, 128'(exhausted), 128'(e.x));
        chk({tag, "_cycles"}, 128'(cyc), 128'(e.cycles));
        chk({tag, "_loads"}, 128'(loads), 128'(e.loads));
        chk({tag, "_block"}, bloque_out, {e.pl, e.nonce});
        chk({tag, "_fin_busy"}, 128'({fin, busy}), 128'(2'b10));
        if (e.f) begin
            chk({tag, "_nonce_out"}, 128'(nonce_out), 128'(e.nonce));
            chk({tag, "_hash_out"}, 128'(hash_out), 128'(e.hash));
        end
    endtask

    localparam logic [95:0] P1 = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] P2 = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
    localparam logic [95:0] P3 = 96'hA5A5_5A5A_FFFF_0000_1357_9BDF;
    localparam logic [95:0] P4 = 96'h0F1E_2D3C_4B5A_6978_8796_A5B4;

    initial begin
        int cyc;
        reset   = 1'b1;
        start   = 1'b1;
        payload = P1;
        target  = 8'h10;
        set_tbl(24'hFFFFFF);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk_idle("reset");
        repeat (6) @(posedge clk);
        #1;
        chk_idle("idle");

        // hit on nonce 0
        tbl[0] = 24'h0F0FAA;
        launch(P1, 8'h10, '{f: 1, x: 0, nonce: 32'd0, hash: 24'h0F0FAA, loads: 1, cycles: LAT + 3, pl: P1});
        wait_result("hit0");
        repeat (3) @(posedge clk);
        #1;
        chk("hit0_hold", 128'({found, nonce_out, hash_out}), 128'({1'b1, 32'd0, 24'h0F0FAA}));

        // restart from DONE; equal-to-target bytes are not hits
        tbl[0] = 24'h2000FF;
        tbl[1] = 24'h1F20FF;
        tbl[2] = 24'h2000FF;
        tbl[3] = 24'h1F1F00;
        launch(P2, 8'h20, '{f: 1, x: 0, nonce: 32'd3, hash: 24'h1F1F00, loads: 4, cycles: 4 * PER + 1, pl: P2});
        wait_result("hit3");

        // target 0 never hits: runs through MAX_NONCE to EXH
        set_tbl(24'h000000);
        launch(P3, 8'h00, '{f: 0, x: 1, nonce: MAXN, hash: 24'h0, loads: 6, cycles: 6 * PER + 1, pl: P3});
        wait_result("exh");
        repeat (4) @(posedge clk);
        #1;
        chk("exh_hold", 128'({exhausted, found, bloque_out[31:0]}), 128'({1'b1, 1'b0, MAXN}));

        // reset while in RUN on nonce 2
        set_tbl(24'h2000FF);
        payload = P2;
        target  = 8'h20;
        start   = 1'b1;
        cyc     = 0;
        while (cyc < 10 * PER) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (bloque_out[31:0] == 32'd2 && core_reset_L && !fin) break;
        end
        chk("midrst_reached", 128'({bloque_out[31:0], core_reset_L, fin}), 128'({32'd2, 1'b1, 1'b0}));
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("midrst");
        repeat (2 * PER) @(posedge clk);
        #1;
        chk_idle("midrst_quiet");

        // new search after abort starts from nonce 0 with the new payload
        tbl[0] = 24'h7F7F00;
        launch(P4, 8'h80, '{f: 1, x: 0, nonce: 32'd0, hash: 24'h7F7F00, loads: 1, cycles: LAT + 3, pl: P4});
        wait_result("after_rst");

        chk("sbq_empty", 128'(sbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
